// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: one holding slot each for ALU and MEM feeding a single register-file write port.
// Optional round-robin for contended grants to different rd: define REGFILE_WB_ARBITER_RR_EN.
module regfile_wb_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_valid,
    input  logic [4:0]   alu_rd,
    input  logic [N-1:0] alu_data,
    output logic         alu_ready,
    input  logic         mem_valid,
    input  logic [4:0]   mem_rd,
    input  logic [N-1:0] mem_data,
    output logic         mem_ready,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic [N-1:0] rf_wdata,
    output logic [31:0]  pend_mask
);

    typedef enum logic [1:0] {IDLE, ONE, BOTH} state_t;

    state_t         state_q, state_d;
    logic           alu_hold_v_q, alu_hold_v_d;
    logic [4:0]     alu_hold_rd_q, alu_hold_rd_d;
    logic [N-1:0]   alu_hold_data_q, alu_hold_data_d;
    logic           alu_hold_age_q, alu_hold_age_d;
    logic           mem_hold_v_q, mem_hold_v_d;
    logic [4:0]     mem_hold_rd_q, mem_hold_rd_d;
    logic [N-1:0]   mem_hold_data_q, mem_hold_data_d;
    logic           mem_hold_age_q, mem_hold_age_d;
    logic           rf_we_q, rf_we_d;
    logic [4:0]     rf_waddr_q, rf_waddr_d;
    logic [N-1:0]   rf_wdata_q, rf_wdata_d;
`ifdef REGFILE_WB_ARBITER_RR_EN
    logic           rr_ptr_q, rr_ptr_d;   // 0: MEM next, 1: ALU next
`endif

    logic alu_grant, mem_grant, same_rd, alu_older;
    logic alu_acc, mem_acc, alu_stay, mem_stay;

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        same_rd   = (alu_hold_rd_q == mem_hold_rd_q) && (alu_hold_rd_q != '0);
        alu_older = alu_hold_age_q && !mem_hold_age_q;
        case (state_q)
            ONE: begin
                alu_grant = alu_hold_v_q;
                mem_grant = mem_hold_v_q;
            end
            BOTH: begin
                // Age ordering beats priority so same-register writes retire in acceptance order
                if (same_rd) begin
                    alu_grant = alu_older;
                    mem_grant = !alu_older;
                end else begin
`ifdef REGFILE_WB_ARBITER_RR_EN
                    alu_grant = rr_ptr_q;
                    mem_grant = !rr_ptr_q;
`else
                    mem_grant = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    assign alu_ready = !alu_hold_v_q || alu_grant;
    assign mem_ready = !mem_hold_v_q || mem_grant;

    always_comb begin
        alu_acc  = alu_valid && alu_ready;
        mem_acc  = mem_valid && mem_ready;
        alu_stay = alu_hold_v_q && !alu_grant;
        mem_stay = mem_hold_v_q && !mem_grant;

        alu_hold_v_d    = alu_acc || alu_stay;
        alu_hold_rd_d   = alu_acc ? alu_rd : alu_hold_rd_q;
        alu_hold_data_d = alu_acc ? alu_data : alu_hold_data_q;
        mem_hold_v_d    = mem_acc || mem_stay;
        mem_hold_rd_d   = mem_acc ? mem_rd : mem_hold_rd_q;
        mem_hold_data_d = mem_acc ? mem_data : mem_hold_data_q;

        alu_hold_age_d = alu_hold_age_q;
        mem_hold_age_d = mem_hold_age_q;
        if (alu_acc && mem_acc) begin
            alu_hold_age_d = 1'b1;
            mem_hold_age_d = 1'b0;
        end else if (alu_acc) begin
            alu_hold_age_d = !mem_stay;
            mem_hold_age_d = mem_stay;
        end else if (mem_acc) begin
            mem_hold_age_d = !alu_stay;
            alu_hold_age_d = alu_stay;
        end

        case ({alu_hold_v_d, mem_hold_v_d})
            2'b00:   state_d = IDLE;
            2'b11:   state_d = BOTH;
            default: state_d = ONE;
        endcase

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_grant && alu_hold_rd_q != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = alu_hold_rd_q;
            rf_wdata_d = alu_hold_data_q;
        end else if (mem_grant && mem_hold_rd_q != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = mem_hold_rd_q;
            rf_wdata_d = mem_hold_data_q;
        end

`ifdef REGFILE_WB_ARBITER_RR_EN
        rr_ptr_d = rr_ptr_q;
        if (state_q == BOTH && !same_rd)
            rr_ptr_d = !rr_ptr_q;
`endif
    end

    always_comb begin
        pend_mask = '0;
        if (alu_hold_v_q) pend_mask = pend_mask | (32'd1 << alu_hold_rd_q);
        if (mem_hold_v_q) pend_mask = pend_mask | (32'd1 << mem_hold_rd_q);
        if (rf_we_q)      pend_mask = pend_mask | (32'd1 << rf_waddr_q);
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            alu_hold_v_q    <= 1'b0;
            alu_hold_rd_q   <= '0;
            alu_hold_data_q <= '0;
            alu_hold_age_q  <= 1'b0;
            mem_hold_v_q    <= 1'b0;
            mem_hold_rd_q   <= '0;
            mem_hold_data_q <= '0;
            mem_hold_age_q  <= 1'b0;
            rf_we_q         <= 1'b0;
            rf_waddr_q      <= '0;
            rf_wdata_q      <= '0;
`ifdef REGFILE_WB_ARBITER_RR_EN
            rr_ptr_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            alu_hold_v_q    <= alu_hold_v_d;
            alu_hold_rd_q   <= alu_hold_rd_d;
            alu_hold_data_q <= alu_hold_data_d;
            alu_hold_age_q  <= alu_hold_age_d;
            mem_hold_v_q    <= mem_hold_v_d;
            mem_hold_rd_q   <= mem_hold_rd_d;
            mem_hold_data_q <= mem_hold_data_d;
            mem_hold_age_q  <= mem_hold_age_d;
            rf_we_q         <= rf_we_d;
            rf_waddr_q      <= rf_waddr_d;
            rf_wdata_q      <= rf_wdata_d;
`ifdef REGFILE_WB_ARBITER_RR_EN
            rr_ptr_q        <= rr_ptr_d;
`endif
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a timestamp-ordered slot model.
module tb_regfile_wb_arbiter;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         alu_valid = 1'b0;
    logic [4:0]   alu_rd = '0;
    logic [N-1:0] alu_data = '0;
    logic         alu_ready;
    logic         mem_valid = 1'b0;
    logic [4:0]   mem_rd = '0;
    logic [N-1:0] mem_data = '0;
    logic         mem_ready;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [N-1:0] rf_wdata;
    logic [31:0]  pend_mask;

    regfile_wb_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = ALU, 1 = MEM; older entries carry smaller acceptance stamps.
    bit           hv [2];
    logic [4:0]   hrd [2];
    logic [N-1:0] hd [2];
    int unsigned  hst [2];
    int unsigned  stamp;
    bit           turn;    // 0: MEM wins next contended grant, 1: ALU
    bit           m_we;
    logic [4:0]   m_addr;
    logic [N-1:0] m_data;

    function automatic int m_grant();
        if (!hv[0] && !hv[1]) return -1;
        if (hv[0] && !hv[1]) return 0;
        if (!hv[0] && hv[1]) return 1;
        if (hrd[0] == hrd[1] && hrd[0] != 0) return (hst[0] < hst[1]) ? 0 : 1;
`ifdef REGFILE_WB_ARBITER_RR_EN
        return turn ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        for (int i = 0; i < 2; i++) if (hv[i]) p[hrd[i]] = 1'b1;
        if (m_we) p[m_addr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hv[0] = 0; hv[1] = 0; turn = 0; stamp = 0;
            m_we = 0; m_addr = '0; m_data = '0;
        end else begin
            int g;
            bit acc0, acc1;
            g = m_grant();
            acc0 = alu_valid && (!hv[0] || g == 0);
            acc1 = mem_valid && (!hv[1] || g == 1);
            if (hv[0] && hv[1] && !(hrd[0] == hrd[1] && hrd[0] != 0)) turn = !turn;
            m_we = 0;
            if (g >= 0) begin
                if (hrd[g] != 0) begin
                    m_we = 1; m_addr = hrd[g]; m_data = hd[g];
                end
                hv[g] = 0;
            end
            if (acc0) begin hv[0] = 1; hrd[0] = alu_rd; hd[0] = alu_data; hst[0] = stamp; stamp++; end
            if (acc1) begin hv[1] = 1; hrd[1] = mem_rd; hd[1] = mem_data; hst[1] = stamp; stamp++; end
        end
    end

    logic [N-1:0] dut_rf [32];
    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            int g;
            g = m_grant();
            check("model_rf_we", {63'd0, rf_we}, {63'd0, m_we});
            if (m_we) begin
                check("model_waddr", {59'd0, rf_waddr}, {59'd0, m_addr});
                check("model_wdata", {32'd0, rf_wdata}, {32'd0, m_data});
            end
            check("model_alu_ready", {63'd0, alu_ready}, {63'd0, (!hv[0] || g == 0)});
            check("model_mem_ready", {63'd0, mem_ready}, {63'd0, (!hv[1] || g == 1)});
            check("model_pend", {32'd0, pend_mask}, {32'd0, m_pend()});
        end
        if (rf_we) dut_rf[rf_waddr] = rf_wdata;
    end

    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
    endtask

    initial begin
        int na, nm;
        #1 cmp_en = 1;
        // Reset values
        #2;
        check("rst_we", {63'd0, rf_we}, 64'd0);
        check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
        check("rst_wdata", {32'd0, rf_wdata}, 64'd0);
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
        check("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
        check("rst_pend", {32'd0, pend_mask}, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Single ALU write
        @(posedge clk); #1 alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        @(posedge clk); #1 alu_valid = 0;
        @(negedge clk);
        check("single_we0", {63'd0, rf_we}, 64'd0);
        check("single_pend_a", {32'd0, pend_mask}, 64'h20);
        @(negedge clk);
        check("single_we1", {63'd0, rf_we}, 64'd1);
        check("single_waddr", {59'd0, rf_waddr}, 64'd5);
        check("single_wdata", {32'd0, rf_wdata}, 64'h1234);
        check("single_pend_b", {32'd0, pend_mask}, 64'h20);
        @(negedge clk);
        check("single_we_off", {63'd0, rf_we}, 64'd0);
        check("single_pend_c", {32'd0, pend_mask}, 64'd0);

        // Simultaneous different rd: MEM first
        @(posedge clk); #1 alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
                           mem_valid = 1; mem_rd = 4; mem_data = 32'h44;
        @(posedge clk); #1 alu_valid = 0; mem_valid = 0;
        @(negedge clk);
        check("both_alu_ready0", {63'd0, alu_ready}, 64'd0);
        check("both_mem_ready1", {63'd0, mem_ready}, 64'd1);
        check("both_pend", {32'd0, pend_mask}, 64'h18);
        @(negedge clk);
        check("both_first_addr", {59'd0, rf_waddr}, 64'd4);
        check("both_first_data", {32'd0, rf_wdata}, 64'h44);
        check("both_alu_ready1", {63'd0, alu_ready}, 64'd1);
        @(negedge clk);
        check("both_second_we", {63'd0, rf_we}, 64'd1);
        check("both_second_addr", {59'd0, rf_waddr}, 64'd3);
        check("both_second_data", {32'd0, rf_wdata}, 64'h33);

        // MEM to x0 is drained silently
        @(posedge clk); #1 mem_valid = 1; mem_rd = 0; mem_data = 32'hFFFF;
        repeat (4) begin
            @(negedge clk);
            check("x0_mem_ready", {63'd0, mem_ready}, 64'd1);
            check("x0_we", {63'd0, rf_we}, 64'd0);
            check("x0_pend", {32'd0, pend_mask}, 64'd0);
        end
        @(posedge clk); #1 mem_valid = 0;
        @(negedge clk);
        check("x0_we_end", {63'd0, rf_we}, 64'd0);

        // Reset while both slots are full
        @(posedge clk); #1 alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
                           mem_valid = 1; mem_rd = 2; mem_data = 32'h22;
        @(posedge clk); #1 alu_valid = 0; mem_valid = 0;
        @(negedge clk);
        check("full_pend", {32'd0, pend_mask}, 64'h6);
        #2 rst = 1'b1;
        #1;
        check("midrst_we", {63'd0, rf_we}, 64'd0);
        check("midrst_alu_ready", {63'd0, alu_ready}, 64'd1);
        check("midrst_mem_ready", {63'd0, mem_ready}, 64'd1);
        check("midrst_pend", {32'd0, pend_mask}, 64'd0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("postrst_we", {63'd0, rf_we}, 64'd0);
        end

        // Same rd: older ALU entry wins over MEM priority
        @(posedge clk); #1 alu_valid = 1; alu_rd = 7; alu_data = 32'hA;
                           mem_valid = 1; mem_rd = 9; mem_data = 32'h9;
        @(posedge clk); #1 alu_valid = 0; mem_rd = 7; mem_data = 32'hB;
        @(posedge clk); #1 mem_valid = 0;
        @(negedge clk);
        check("age_w1_addr", {59'd0, rf_waddr}, 64'd9);
        check("age_pend", {32'd0, pend_mask}, 64'h280);
        @(negedge clk);
        check("age_w2_addr", {59'd0, rf_waddr}, 64'd7);
        check("age_w2_data", {32'd0, rf_wdata}, 64'hA);
        @(negedge clk);
        check("age_w3_we", {63'd0, rf_we}, 64'd1);
        check("age_w3_data", {32'd0, rf_wdata}, 64'hB);
        @(negedge clk);
        check("age_x7_final", {32'd0, dut_rf[7]}, 64'hB);

`ifdef REGFILE_WB_ARBITER_RR_EN
        // Round robin under sustained contention
        do_reset();
        @(posedge clk); #1 alu_valid = 1; alu_rd = 10; alu_data = 32'hAA;
                           mem_valid = 1; mem_rd = 11; mem_data = 32'hBB;
        @(negedge clk);
        na = 0; nm = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_we", {63'd0, rf_we}, 64'd1);
            check("rr_order", {59'd0, rf_waddr}, (i % 2 == 0) ? 64'd11 : 64'd10);
            if (rf_waddr == 5'd10) na++;
            if (rf_waddr == 5'd11) nm++;
        end
        check("rr_alu_count", 64'(na), 64'd4);
        check("rr_mem_count", 64'(nm), 64'd4);
        @(posedge clk); #1 alu_valid = 0; mem_valid = 0;
        repeat (3) @(negedge clk);
`else
        na = 0; nm = 0;
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = 5'($urandom_range(0, 6));
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 2) != 0);
            mem_rd    = 5'($urandom_range(0, 6));
            mem_data  = $urandom;
            if (i == 300) begin
                @(negedge clk); #2 rst = 1'b1;
                @(negedge clk); #2 rst = 1'b0;
            end
        end
        @(posedge clk); #1 alu_valid = 0; mem_valid = 0;
        repeat (4) @(negedge clk);
        check("drain_idle_pend", {32'd0, pend_mask}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the data width of every write-data path.
REQ-002 The block SHALL have port clk, input, 1: clock; all state updates on posedge.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 The block SHALL have ports alu_valid (input, 1), alu_rd (input, 5) and alu_data (input, N): the ALU writeback request.
REQ-005 The block SHALL have port alu_ready, output, 1: the ALU holding slot can accept this cycle.
REQ-006 The block SHALL have ports mem_valid (input, 1), mem_rd (input, 5) and mem_data (input, N): the load writeback request.
REQ-007 The block SHALL have port mem_ready, output, 1: the MEM holding slot can accept this cycle.
REQ-008 The block SHALL have ports rf_we (output, 1), rf_waddr (output, 5) and rf_wdata (output, N), all registered, driving the register file's single write port.
REQ-009 The block SHALL have port pend_mask, output, 32: bit r is set while any write to xr is held or staged.

Function
REQ-010 Each requester SHALL own one holding slot (valid, rd, data, age bit); a transfer occurs on a posedge where valid && ready.
REQ-011 alu_ready SHALL equal !alu_hold_v || alu_grant, and mem_ready SHALL be the same for MEM; neither depends on the requester's own valid.
REQ-012 The arbiter state machine SHALL have states IDLE (no slot valid), ONE (one slot valid) and BOTH (both slots valid), recomputed each posedge from the slot valid bits after accept and drain.
REQ-013 In ONE, the valid slot SHALL be granted every cycle.
REQ-014 In BOTH with different rd, the MEM slot SHALL be granted unless the configuration feature overrides this.
REQ-015 In BOTH with equal nonzero rd, the older slot (age bit) SHALL be granted regardless of priority, so write order to a register matches acceptance order.
REQ-016 When both requesters are accepted on the same edge with equal rd, the ALU entry SHALL be treated as older.
REQ-017 On grant, rf_we<=1, rf_waddr<=slot.rd and rf_wdata<=slot.data at the next posedge, and the slot SHALL be freed at that same edge.
REQ-018 Latency SHALL be: accept at edge k, earliest rf_we at edge k+1, and the register-file write at the following negedge.
REQ-019 A granted slot with rd==0 SHALL be drained with rf_we<=0, taking a full cycle with no write issued.
REQ-020 When no slot is granted, rf_we<=0 and rf_waddr/rf_wdata SHALL hold their previous values.
REQ-021 A drained slot SHALL be refillable on the same edge (throughput of one per requester per cycle when uncontended).
REQ-022 pend_mask SHALL be combinational: it is the OR of one-hot(rd) for each valid slot and for the output stage when rf_we=1; bit 0 is always 0.
REQ-023 Sustained contention SHALL stall the losing requester via ready=0, and data SHALL never be dropped or duplicated.

Reset
REQ-024 While rst=1, all slot valid bits SHALL be 0, the state SHALL be IDLE, rf_we=0, rf_waddr=0, rf_wdata=0 and the RR pointer=0 (MEM first).
REQ-025 While rst=1, alu_ready=1, mem_ready=1 and pend_mask=0.
REQ-026 Reset asserted mid-operation SHALL discard held entries, and no rf_we pulse SHALL occur after rst rises.

Configuration
REQ-027 With macro REGFILE_WB_ARBITER_RR_EN defined, BOTH with different rd SHALL use a round-robin pointer that flips to the other requester after each contended grant.
REQ-028 With REGFILE_WB_ARBITER_RR_EN undefined, fixed MEM priority SHALL apply and no pointer register SHALL exist.
REQ-029 REQ-015 age ordering SHALL take precedence in both configurations.

Verification
REQ-030 Reset then single ALU write (rd=5, data=0x1234) -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 exactly one cycle after accept; pend_mask[5] is high for 2 cycles.
REQ-031 ALU rd=3 and MEM rd=4 valid on the same edge, RR off -> write rd=4 then rd=3 on consecutive cycles; alu_ready=0 for one cycle.
REQ-032 ALU rd=7 (0xA) accepted one cycle before MEM rd=7 (0xB) -> writes to x7 occur in order 0xA then 0xB; final x7=0xB.
REQ-033 MEM rd=0 data=0xFFFF -> mem_ready stays 1, rf_we stays 0 for the whole sequence, and pend_mask stays 0.
REQ-034 RR on, both requesters continuously valid with distinct rd for 8 cycles -> grants alternate M,A,M,A,... with 4 grants each.
REQ-035 rst pulse while both slots are full -> rf_we=0 immediately, both readys=1, pend_mask=0, and no stale write after release.
